// File: rtl/s27_bist_ctrl.sv
// Scan BIST sequencer for the s27 core: LFSR-driven shift/capture patterns,
// MISR compaction of scan-out and G17, and a signature check against GOLDEN.
module s27_bist_ctrl #(
  parameter int          N_PATTERNS = 15,
  parameter int          CHAIN_LEN  = 3,
  parameter logic [7:0]  LFSR_SEED  = 8'h01,
  parameter logic [7:0]  MISR_POLY  = 8'h1D,
  parameter logic [7:0]  GOLDEN     = 8'h00
) (
  input  logic       ck_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic [3:0] pi_out_o,
  output logic       se_o,
  output logic       si_o,
  input  logic       so_i,
  input  logic       po_in_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] signature_o
);

  localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam int BW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int PW = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] PAT_LAST = PW'(N_PATTERNS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_CAPTURE, S_UNLOAD, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [7:0]    misr_q, misr_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [3:0]    pi_q, pi_d;
  logic          se_q, se_d;
  logic          si_q, si_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [7:0]    sig_q, sig_d;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[4], l[7:1]};
  endfunction

  function automatic logic [7:0] misr_next(input logic [7:0] m, input logic b);
    return {m[6:0], 1'b0} ^ ((m[7] ^ b) ? MISR_POLY : 8'h00);
  endfunction

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    bit_d   = bit_q;
    pat_d   = pat_q;
    pi_d    = pi_q;
    se_d    = 1'b0;
    si_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    sig_d   = sig_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_SHIFT;
          misr_d  = 8'h00;
          bit_d   = '0;
          pat_d   = '0;
          si_d    = SEED_EFF[0];
          lfsr_d  = lfsr_next(SEED_EFF);
          se_d    = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_SHIFT: begin
        // Chain holds unknown pre-run data while the first pattern loads.
        if (pat_q != '0) misr_d = misr_next(misr_q, so_i);
        lfsr_d = lfsr_next(lfsr_q);
        if (bit_q == BIT_LAST) begin
          state_d = S_CAPTURE;
          pi_d    = lfsr_q[3:0];
        end else begin
          bit_d = bit_q + 1'b1;
          se_d  = 1'b1;
          si_d  = lfsr_q[0];
        end
      end
      S_CAPTURE: begin
        misr_d = misr_next(misr_q, po_in_i);
        bit_d  = '0;
        se_d   = 1'b1;
        if (pat_q != PAT_LAST) begin
          state_d = S_SHIFT;
          pat_d   = pat_q + 1'b1;
          si_d    = lfsr_q[0];
          lfsr_d  = lfsr_next(lfsr_q);
        end else begin
          state_d = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        misr_d = misr_next(misr_q, so_i);
        if (bit_q == BIT_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sig_d   = misr_d;
          pass_d  = (misr_d == GOLDEN);
        end else begin
          bit_d = bit_q + 1'b1;
          se_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ck_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      misr_q  <= 8'h00;
      bit_q   <= '0;
      pat_q   <= '0;
      pi_q    <= 4'h0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      sig_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      bit_q   <= bit_d;
      pat_q   <= pat_d;
      pi_q    <= pi_d;
      se_q    <= se_d;
      si_q    <= si_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      sig_q   <= sig_d;
    end
  end

  assign pi_out_o    = pi_q;
  assign se_o        = se_q;
  assign si_o        = si_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign signature_o = sig_q;

endmodule
